// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter: FSM encoding, requester ids, default widths.
// Pure declarations, no timing of its own.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

  // Round-robin pick: on a tie the requester that was not granted last time wins.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last_grant);
    if (r0 && r1) return ~last_grant;
    return r1 ? REQ_DCACHE : REQ_ICACHE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter.
// slave = arbiter's view, master = the caches/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              we0;
  logic              we1;
  logic [LINE_W-1:0] wdata0;
  logic [LINE_W-1:0] wdata1;
  logic              resp_valid0;
  logic              resp_valid1;
  logic [LINE_W-1:0] resp_data0;
  logic [LINE_W-1:0] resp_data1;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;
  logic              busy;
  logic              owner;

  modport slave (
    input  req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, mem_ack, mem_rdata,
    output resp_valid0, resp_valid1, resp_data0, resp_data1,
    output mem_req, mem_addr, mem_we, mem_wdata, busy, owner
  );

  modport master (
    output req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, mem_ack, mem_rdata,
    input  resp_valid0, resp_valid1, resp_data0, resp_data1,
    input  mem_req, mem_addr, mem_we, mem_wdata, busy, owner
  );

endinterface

// File: rtl/mem_port_arbiter_demux.sv
// 1-to-2 demux: steers din to the selected output, the other output is held at zero.
// Purely combinational, no flow control.
module mem_port_arbiter_demux #(
  parameter int N = 128
) (
  input  logic [N-1:0] din,
  input  logic         sel,
  output logic [N-1:0] dout0,
  output logic [N-1:0] dout1
);

  assign dout0 = sel ? '0  : din;
  assign dout1 = sel ? din : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache (0) and dcache (1), round-robin, one transaction in flight.
// Grant -> mem_req next cycle; mem_ack -> one-cycle resp_valid next cycle; requests wait while busy.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic              owner_q;
  logic              winner;
  logic              any_req;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata_q;
  logic [LINE_W-1:0] resp_in;
  logic              resp_vld;

  assign any_req = bus.req0 | bus.req1;
  assign winner  = pick_winner(bus.req0, bus.req1, last_grant_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (bus.mem_ack) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_DCACHE;
      owner_q      <= REQ_ICACHE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      // Request fields are captured once at grant so the port stays stable while busy.
      if (state_q == IDLE && any_req) begin
        owner_q      <= winner;
        last_grant_q <= winner;
        addr_q       <= (winner == REQ_DCACHE) ? bus.addr1  : bus.addr0;
        we_q         <= (winner == REQ_DCACHE) ? bus.we1    : bus.we0;
        wdata_q      <= (winner == REQ_DCACHE) ? bus.wdata1 : bus.wdata0;
      end
      if (state_q == BUSY && bus.mem_ack) rdata_q <= bus.mem_rdata;
    end
  end

  // Outputs decode registered state only; nothing flows straight from inputs.
  assign resp_vld = (state_q == RESP);
  assign resp_in  = resp_vld ? rdata_q : '0;

  mem_port_arbiter_demux #(.N(LINE_W)) u_data_demux (
    .din   (resp_in),
    .sel   (owner_q),
    .dout0 (bus.resp_data0),
    .dout1 (bus.resp_data1)
  );

  mem_port_arbiter_demux #(.N(1)) u_valid_demux (
    .din   (resp_vld),
    .sel   (owner_q),
    .dout0 (bus.resp_valid0),
    .dout1 (bus.resp_valid1)
  );

  assign bus.mem_req   = (state_q == BUSY);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for read/tie/write flows,
// hand-written sequences for stability, spurious ack, dropped req and mid-flight reset.
module tb_mem_port_arbiter;

  localparam logic [127:0] ZERO = 128'h0;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] D    = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [127:0] W0   = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
  localparam logic [127:0] W1   = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
  localparam logic [127:0] R1   = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
  localparam logic [127:0] R2   = 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
  localparam logic [127:0] R3   = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic         rst_n, req0, req1, we0, we1, ack;
    logic [31:0]  a0, a1;
    logic [127:0] wd0, wd1, rd;
    logic         eb, emr, eo, ev0, ev1;
    logic [31:0]  ea;
    logic         ewe;
    logic [127:0] ewd, ed0, ed1;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(
    input logic rs, input logic r0, input logic r1, input logic w0, input logic w1, input logic ack,
    input logic [31:0] a0, input logic [31:0] a1,
    input logic [127:0] wd0, input logic [127:0] wd1, input logic [127:0] rd,
    input logic eb, input logic emr, input logic eo, input logic ev0, input logic ev1,
    input logic [31:0] ea, input logic ewe,
    input logic [127:0] ewd, input logic [127:0] ed0, input logic [127:0] ed1);
    vec_t v;
    v.rst_n = rs; v.req0 = r0; v.req1 = r1; v.we0 = w0; v.we1 = w1; v.ack = ack;
    v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1; v.rd = rd;
    v.eb = eb; v.emr = emr; v.eo = eo; v.ev0 = ev0; v.ev1 = ev1;
    v.ea = ea; v.ewe = ewe; v.ewd = ewd; v.ed0 = ed0; v.ed1 = ed1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, " busy"},      bus.busy,        v.eb);
    chk({tag, " mem_req"},   bus.mem_req,     v.emr);
    chk({tag, " owner"},     bus.owner,       v.eo);
    chk({tag, " rv0"},       bus.resp_valid0, v.ev0);
    chk({tag, " rv1"},       bus.resp_valid1, v.ev1);
    chk({tag, " mem_addr"},  bus.mem_addr,    v.ea);
    chk({tag, " mem_we"},    bus.mem_we,      v.ewe);
    chk({tag, " mem_wdata"}, bus.mem_wdata,   v.ewd);
    chk({tag, " rd0"},       bus.resp_data0,  v.ed0);
    chk({tag, " rd1"},       bus.resp_data1,  v.ed1);
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0; bus.mem_ack = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0; bus.mem_rdata = '0;
  endtask

  initial begin
    // single read, reset, tie pair, repeat tie, write by requester 1
    vecs[0]  = mk(1,1,0,0,0,0, 32'h100,32'h0,  W0,ZERO,ZERO, 1,1,0,0,0, 32'h100,0,W0,ZERO,ZERO);
    vecs[1]  = mk(1,1,0,0,0,0, 32'h100,32'h0,  W0,ZERO,ZERO, 1,1,0,0,0, 32'h100,0,W0,ZERO,ZERO);
    vecs[2]  = mk(1,1,0,0,0,0, 32'h100,32'h0,  W0,ZERO,ZERO, 1,1,0,0,0, 32'h100,0,W0,ZERO,ZERO);
    vecs[3]  = mk(1,1,0,0,0,1, 32'h100,32'h0,  W0,ZERO,D,    1,0,0,1,0, 32'h100,0,W0,D,ZERO);
    vecs[4]  = mk(1,0,0,0,0,0, 32'h100,32'h0,  W0,ZERO,ZERO, 0,0,0,0,0, 32'h100,0,W0,ZERO,ZERO);
    vecs[5]  = mk(0,1,1,0,0,0, 32'h200,32'h300,W0,W1,ZERO,   0,0,0,0,0, 32'h0,0,ZERO,ZERO,ZERO);
    vecs[6]  = mk(1,1,1,0,0,0, 32'h200,32'h300,W0,W1,ZERO,   1,1,0,0,0, 32'h200,0,W0,ZERO,ZERO);
    vecs[7]  = mk(1,1,1,0,0,1, 32'h200,32'h300,W0,W1,R1,     1,0,0,1,0, 32'h200,0,W0,R1,ZERO);
    vecs[8]  = mk(1,0,1,0,0,0, 32'h200,32'h300,W0,W1,ZERO,   0,0,0,0,0, 32'h200,0,W0,ZERO,ZERO);
    vecs[9]  = mk(1,0,1,0,0,0, 32'h200,32'h300,W0,W1,ZERO,   1,1,1,0,0, 32'h300,0,W1,ZERO,ZERO);
    vecs[10] = mk(1,0,1,0,0,1, 32'h200,32'h300,W0,W1,R2,     1,0,1,0,1, 32'h300,0,W1,ZERO,R2);
    vecs[11] = mk(1,0,0,0,0,0, 32'h200,32'h300,W0,W1,ZERO,   0,0,1,0,0, 32'h300,0,W1,ZERO,ZERO);
    vecs[12] = mk(1,1,1,0,0,0, 32'h200,32'h300,W0,W1,ZERO,   1,1,0,0,0, 32'h200,0,W0,ZERO,ZERO);
    vecs[13] = mk(1,1,1,0,0,1, 32'h200,32'h300,W0,W1,R1,     1,0,0,1,0, 32'h200,0,W0,R1,ZERO);
    vecs[14] = mk(1,0,0,0,0,0, 32'h200,32'h300,W0,W1,ZERO,   0,0,0,0,0, 32'h200,0,W0,ZERO,ZERO);
    vecs[15] = mk(1,0,1,0,1,0, 32'h200,32'h40, W0,ONES,ZERO, 1,1,1,0,0, 32'h40,1,ONES,ZERO,ZERO);
    vecs[16] = mk(1,0,1,0,1,1, 32'h200,32'h40, W0,ONES,R3,   1,0,1,0,1, 32'h40,1,ONES,ZERO,R3);
    vecs[17] = mk(1,0,0,0,0,0, 32'h200,32'h40, W0,ONES,ZERO, 0,0,1,0,0, 32'h40,1,ONES,ZERO,ZERO);

    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    check_all("reset", mk(1,0,0,0,0,0, 0,0,ZERO,ZERO,ZERO, 0,0,0,0,0, 32'h0,0,ZERO,ZERO,ZERO));
    rst_n = 1;

    for (int i = 0; i < 18; i++) begin
      rst_n         = vecs[i].rst_n;
      bus.req0      = vecs[i].req0;
      bus.req1      = vecs[i].req1;
      bus.we0       = vecs[i].we0;
      bus.we1       = vecs[i].we1;
      bus.mem_ack   = vecs[i].ack;
      bus.addr0     = vecs[i].a0;
      bus.addr1     = vecs[i].a1;
      bus.wdata0    = vecs[i].wd0;
      bus.wdata1    = vecs[i].wd1;
      bus.mem_rdata = vecs[i].rd;
      tick();
      check_all($sformatf("v%0d", i), vecs[i]);
    end
    idle_inputs();
    rst_n = 1;

    // request fields must stay latched while BUSY
    bus.req0 = 1; bus.addr0 = 32'h500; bus.wdata0 = W0;
    tick();
    chk("stab grant mem_req", bus.mem_req, 1'b1);
    chk("stab grant owner", bus.owner, 1'b0);
    bus.addr0 = 32'h600; bus.wdata0 = W1; bus.we0 = 1;
    tick();
    tick();
    chk("stab mem_addr", bus.mem_addr, 32'h500);
    chk("stab mem_wdata", bus.mem_wdata, W0);
    chk("stab mem_we", bus.mem_we, 1'b0);
    bus.mem_ack = 1; bus.mem_rdata = R1;
    tick();
    bus.mem_ack = 0; bus.mem_rdata = '0; bus.req0 = 0; bus.we0 = 0;
    chk("stab rv0", bus.resp_valid0, 1'b1);
    chk("stab rd0", bus.resp_data0, R1);
    tick();
    chk("stab idle busy", bus.busy, 1'b0);

    // spurious ack in IDLE
    bus.mem_ack = 1; bus.mem_rdata = R2;
    tick();
    bus.mem_ack = 0; bus.mem_rdata = '0;
    chk("spur rv0", bus.resp_valid0, 1'b0);
    chk("spur rv1", bus.resp_valid1, 1'b0);
    chk("spur busy", bus.busy, 1'b0);
    chk("spur rd0", bus.resp_data0, ZERO);
    tick();
    chk("spur later rv", {bus.resp_valid0, bus.resp_valid1}, 2'b00);

    // req1 dropped mid-BUSY still completes
    bus.req1 = 1; bus.addr1 = 32'h700; bus.wdata1 = W1;
    tick();
    chk("drop owner", bus.owner, 1'b1);
    chk("drop mem_req", bus.mem_req, 1'b1);
    bus.req1 = 0;
    tick();
    chk("drop still busy", bus.busy, 1'b1);
    chk("drop still mem_req", bus.mem_req, 1'b1);
    bus.mem_ack = 1; bus.mem_rdata = R3;
    tick();
    bus.mem_ack = 0; bus.mem_rdata = '0;
    chk("drop rv1", bus.resp_valid1, 1'b1);
    chk("drop rd1", bus.resp_data1, R3);
    chk("drop rv0", bus.resp_valid0, 1'b0);
    tick();
    chk("drop rv1 once", bus.resp_valid1, 1'b0);
    chk("drop idle", bus.busy, 1'b0);

    // reset while BUSY drops the transaction
    bus.req0 = 1; bus.addr0 = 32'h800;
    tick();
    chk("rst pre mem_req", bus.mem_req, 1'b1);
    rst_n = 0; bus.req0 = 0;
    tick();
    chk("rst mem_req", bus.mem_req, 1'b0);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst mem_addr", bus.mem_addr, 32'h0);
    rst_n = 1;
    bus.mem_ack = 1; bus.mem_rdata = R1;
    tick();
    bus.mem_ack = 0; bus.mem_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rst late ack rv c%0d", c), {bus.resp_valid0, bus.resp_valid1}, 2'b00);
      chk($sformatf("rst late ack busy c%0d", c), bus.busy, 1'b0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
